// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_io_responder
//  Purpose  : Responder end of the CPU byte-wide memory bus. Holds a 128 KB
//             single-port RAM and the memory-mapped I/O block at 0x30000+
//             (rx byte FIFO, tx byte FIFO, free-running cycle counter with
//             little-endian snapshot, sticky program-stop flag).
//  Ports    : clk_in, rst_in (async, active-low), rdy_in
//             cpu_en_i / cpu_addr_i / cpu_wr_i / cpu_wdata_i -> cpu_rdata_o
//             rx_data_i / rx_valid_i -> rx_ready_o   (input stream)
//             tx_data_o / tx_valid_o <- tx_ready_i   (output stream)
//             prog_stop_o, tx_ovf_o                  (sticky flags)
//  Revision : 1.0  initial release
// ============================================================================
module ram_io_responder #(
  parameter int ADDR_WIDTH      = 17,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        cpu_en_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        prog_stop_o,
  output logic        tx_ovf_o
);

  localparam int                   c_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] c_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0] c_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0] c_ZERO = '0;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [7:0] r_ram    [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] r_rx_mem [0:c_DEPTH-1];
  logic [7:0] r_tx_mem [0:c_DEPTH-1];

  logic [FIFO_DEPTH_LOG2-1:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
  logic [FIFO_DEPTH_LOG2:0]   r_rx_cnt, r_tx_cnt;
  logic                       r_rx_ready;
  logic [31:0]                r_cnt;
  logic [31:8]                r_snap;   // byte 0 is returned live, never from here
  logic [7:0]                 r_rdata;
  logic                       r_stop;
  logic                       r_ovf;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic        w_act, w_io, w_rd, w_wr;
  logic [15:0] w_off;
  logic        w_off0, w_off4;
  logic        w_unused;

  assign w_act  = rdy_in & cpu_en_i;
  assign w_io   = (cpu_addr_i[17:16] == 2'b11);
  assign w_off  = cpu_addr_i[15:0];
  assign w_off0 = (w_off == 16'h0000);
  assign w_off4 = (w_off == 16'h0004);
  assign w_rd   = w_act & ~cpu_wr_i;
  assign w_wr   = w_act &  cpu_wr_i;
  assign w_unused = ^cpu_addr_i[31:18];

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic w_rx_empty, w_rx_push, w_rx_pop;
  logic w_tx_empty, w_tx_full, w_tx_req, w_tx_push, w_tx_pop;
  logic [7:0] w_tx_byte;
  logic [FIFO_DEPTH_LOG2:0] w_rx_cnt_nxt, w_tx_cnt_nxt;

  assign w_rx_empty = (r_rx_cnt == c_ZERO);
  assign w_rx_push  = rx_valid_i & r_rx_ready;
  // Pop only judges registered occupancy, so a same-cycle push is never bypassed.
  assign w_rx_pop   = w_rd & w_io & w_off0 & ~w_rx_empty;

  assign w_tx_empty = (r_tx_cnt == c_ZERO);
  assign w_tx_full  = (r_tx_cnt == c_FULL);
  // A 0x00 written to the data port is ignored; the stop port injects 0x00.
  assign w_tx_req   = w_wr & w_io & ((w_off0 & (cpu_wdata_i != 8'h00)) | w_off4);
  assign w_tx_byte  = w_off4 ? 8'h00 : cpu_wdata_i;
  // Full is judged before any same-cycle pop, so a full FIFO always drops.
  assign w_tx_push  = w_tx_req & ~w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & tx_ready_i;

  always_comb begin
    w_rx_cnt_nxt = r_rx_cnt;
    if (w_rx_push & ~w_rx_pop)      w_rx_cnt_nxt = r_rx_cnt + c_ONE;
    else if (~w_rx_push & w_rx_pop) w_rx_cnt_nxt = r_rx_cnt - c_ONE;
  end

  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    if (w_tx_push & ~w_tx_pop)      w_tx_cnt_nxt = r_tx_cnt + c_ONE;
    else if (~w_tx_push & w_tx_pop) w_tx_cnt_nxt = r_tx_cnt - c_ONE;
  end

  // --------------------------------------------------------------------------
  // Read data mux
  // --------------------------------------------------------------------------
  logic [7:0] w_rdata_nxt;

  always_comb begin
    w_rdata_nxt = 8'h00;
    if (w_io) begin
      case (w_off)
        16'h0000: w_rdata_nxt = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
        16'h0004: w_rdata_nxt = r_cnt[7:0];
        16'h0005: w_rdata_nxt = r_snap[15:8];
        16'h0006: w_rdata_nxt = r_snap[23:16];
        16'h0007: w_rdata_nxt = r_snap[31:24];
        default:  w_rdata_nxt = 8'h00;
      endcase
    end else begin
      w_rdata_nxt = r_ram[cpu_addr_i[ADDR_WIDTH-1:0]];
    end
  end

  // --------------------------------------------------------------------------
  // Memories (no reset on contents)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_wr & ~w_io) r_ram[cpu_addr_i[ADDR_WIDTH-1:0]] <= cpu_wdata_i;
    if (w_rx_push)    r_rx_mem[r_rx_wr] <= rx_data_i;
    if (w_tx_push)    r_tx_mem[r_tx_wr] <= w_tx_byte;
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_cnt   <= '0;
      r_rx_ready <= 1'b0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_cnt   <= '0;
      r_cnt      <= 32'h0;
      r_snap     <= 24'h0;
      r_rdata    <= 8'h00;
      r_stop     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + 32'h1;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_ready <= (w_rx_cnt_nxt != c_FULL);
      r_tx_cnt   <= w_tx_cnt_nxt;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_rd) r_rdata <= w_rdata_nxt;
      if (w_rd & w_io & w_off4) r_snap <= r_cnt[31:8];
      if (w_wr & w_io & w_off4) r_stop <= 1'b1;
      if (w_tx_req & w_tx_full) r_ovf  <= 1'b1;
    end
  end

  assign cpu_rdata_o = r_rdata;
  assign rx_ready_o  = r_rx_ready;
  assign tx_valid_o  = ~w_tx_empty;
  // Head entry is gated so the stream shows 0x00 while empty or in reset.
  assign tx_data_o   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];
  assign prog_stop_o = r_stop;
  assign tx_ovf_o    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_io_responder
//  Purpose  : Self-checking bench for ram_io_responder: a table of directed
//             bus/stream vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        cpu_en_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_wdata_i;
  logic [7:0]  cpu_rdata_o;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        prog_stop_o;
  logic        tx_ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference cycle counter: value the DUT counter must hold between edges.
  logic [31:0] cyc;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cyc <= 32'h0;
    else         cyc <= cyc + 32'h1;
  end

  ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH_LOG2(3)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .cpu_en_i    (cpu_en_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .prog_stop_o (prog_stop_o),
    .tx_ovf_o    (tx_ovf_o)
  );

  typedef struct {
    logic        wr;
    logic        en;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic wr, input logic en, input logic [31:0] addr,
                              input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                              input logic txr, input logic chk_rd, input logic [7:0] exp_rd,
                              input logic exp_txv, input logic [7:0] exp_txd);
    vec_t v;
    v.wr = wr; v.en = en; v.addr = addr; v.wd = wd; v.rxv = rxv; v.rxd = rxd;
    v.txr = txr; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_txv = exp_txv;
    v.exp_txd = exp_txd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [31:0] addr, input logic [7:0] wd);
    cpu_en_i = 1'b1; cpu_wr_i = wr; cpu_addr_i = addr; cpu_wdata_i = wd;
  endtask

  task automatic idle();
    cpu_en_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdata"},    cpu_rdata_o, 8'h00);
    check({tag, " rx_ready"}, rx_ready_o,  1'b0);
    check({tag, " tx_valid"}, tx_valid_o,  1'b0);
    check({tag, " tx_data"},  tx_data_o,   8'h00);
    check({tag, " stop"},     prog_stop_o, 1'b0);
    check({tag, " ovf"},      tx_ovf_o,    1'b0);
  endtask

  logic [31:0] snap;

  initial begin
    // Directed table: RAM round trips, rx reads, tx writes and drain.
    vecs[0]  = mk(1, 1, 32'h00010, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 1, 32'h00010, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 8'h00);
    vecs[2]  = mk(1, 1, 32'h1FFFF, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(0, 1, 32'h1FFFF, 8'h00, 0, 8'h00, 0, 1, 8'h3C, 0, 8'h00);
    vecs[4]  = mk(0, 1, 32'h00010, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 8'h00);
    vecs[5]  = mk(0, 0, 32'h00000, 8'h00, 1, 8'h41, 0, 0, 8'h00, 0, 8'h00);
    vecs[6]  = mk(0, 0, 32'h00000, 8'h00, 1, 8'h42, 0, 0, 8'h00, 0, 8'h00);
    vecs[7]  = mk(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00);
    vecs[8]  = mk(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 1, 8'h42, 0, 8'h00);
    vecs[9]  = mk(0, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00);
    vecs[10] = mk(1, 1, 32'h30000, 8'h48, 0, 8'h00, 0, 0, 8'h00, 1, 8'h48);
    vecs[11] = mk(1, 1, 32'h30000, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 8'h48);
    vecs[12] = mk(1, 1, 32'h30000, 8'h49, 0, 8'h00, 0, 0, 8'h00, 1, 8'h48);
    vecs[13] = mk(0, 0, 32'h00000, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h49);
    vecs[14] = mk(0, 0, 32'h00000, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[15] = mk(0, 0, 32'h00000, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);

    rst_in = 1'b0; rdy_in = 1'b1; idle();
    rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;

    // Reset state, before and after clock edges while held in reset.
    #1;
    check_reset_outputs("reset_t0");
    @(negedge clk_in); @(negedge clk_in);
    check_reset_outputs("reset_held");
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rx_ready_after_reset", rx_ready_o, 1'b1);

    // Table vectors.
    for (int i = 0; i < 16; i++) begin
      cpu_en_i = vecs[i].en; cpu_wr_i = vecs[i].wr; cpu_addr_i = vecs[i].addr;
      cpu_wdata_i = vecs[i].wd; rx_valid_i = vecs[i].rxv; rx_data_i = vecs[i].rxd;
      tx_ready_i = vecs[i].txr;
      @(negedge clk_in);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), cpu_rdata_o, vecs[i].exp_rd);
      check($sformatf("vec%0d tx_valid", i), tx_valid_o, vecs[i].exp_txv);
      check($sformatf("vec%0d tx_data", i),  tx_data_o,  vecs[i].exp_txd);
      check($sformatf("vec%0d rx_ready", i), rx_ready_o, 1'b1);
    end
    rx_valid_i = 1'b0; tx_ready_i = 1'b0; idle();

    // tx overflow: 9 writes into an 8-deep FIFO with no consumer.
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, 32'h30000, 8'(i));
      @(negedge clk_in);
      if (i == 8) check("ovf_after_8", tx_ovf_o, 1'b0);
    end
    idle();
    check("ovf_after_9", tx_ovf_o, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tx_ready_i = 1'b1;
      check($sformatf("drain%0d valid", i), tx_valid_o, 1'b1);
      check($sformatf("drain%0d data", i),  tx_data_o,  8'(i));
      @(negedge clk_in);
    end
    tx_ready_i = 1'b0;
    check("drain_empty", tx_valid_o, 1'b0);
    check("ovf_sticky", tx_ovf_o, 1'b1);

    // rdy_in = 0 must freeze reads and pops.
    rx_valid_i = 1'b1; rx_data_i = 8'h55; @(negedge clk_in);
    rx_data_i = 8'h66; @(negedge clk_in);
    rx_valid_i = 1'b0;
    bus(1'b0, 32'h30000, 8'h00); @(negedge clk_in);
    check("rx_first", cpu_rdata_o, 8'h55);
    rdy_in = 1'b0;
    @(negedge clk_in); check("rdy0_hold1", cpu_rdata_o, 8'h55);
    @(negedge clk_in); check("rdy0_hold2", cpu_rdata_o, 8'h55);
    rdy_in = 1'b1;
    @(negedge clk_in); check("rx_no_pop", cpu_rdata_o, 8'h66);
    @(negedge clk_in); check("rx_empty_read", cpu_rdata_o, 8'h00);
    idle();

    // Counter snapshot, well past 256 cycles so upper bytes are non-trivial.
    repeat (300) @(negedge clk_in);
    bus(1'b0, 32'h30004, 8'h00);
    snap = cyc;
    @(negedge clk_in); check("cnt_b0", cpu_rdata_o, snap[7:0]);
    bus(1'b0, 32'h30005, 8'h00);
    @(negedge clk_in); check("cnt_b1", cpu_rdata_o, snap[15:8]);
    bus(1'b0, 32'h30006, 8'h00);
    @(negedge clk_in); check("cnt_b2", cpu_rdata_o, snap[23:16]);
    bus(1'b0, 32'h30007, 8'h00);
    @(negedge clk_in); check("cnt_b3", cpu_rdata_o, snap[31:24]);
    check("cnt_b1_nonzero", (snap[15:8] != 8'h00), 1'b1);
    bus(1'b0, 32'h30008, 8'h00);
    @(negedge clk_in); check("io_other_read", cpu_rdata_o, 8'h00);

    // Stop write, then asynchronous reset mid-transfer.
    bus(1'b0, 32'h00010, 8'h00);
    @(negedge clk_in); check("ram_reread", cpu_rdata_o, 8'hA5);
    bus(1'b1, 32'h30004, 8'h99);
    @(negedge clk_in);
    check("stop_set", prog_stop_o, 1'b1);
    check("stop_tx_valid", tx_valid_o, 1'b1);
    check("stop_tx_zero", tx_data_o, 8'h00);
    bus(1'b1, 32'h30000, 8'h77);
    @(negedge clk_in);
    idle();
    check("stop_sticky", prog_stop_o, 1'b1);
    check("ram_rdata_kept", cpu_rdata_o, 8'hA5);
    #2 rst_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #10 rst_in = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
